// File: rtl/dsp48_a1_pkg.sv
// ---------------------------------------------------------------------------
// dsp48_a1_pkg
// Shared definitions for the DSP48_A1 slice: where each control field lives
// inside the OPMODE word, and the select codes of the X and Z post-adder
// multiplexers.
// ---------------------------------------------------------------------------
package dsp48_a1_pkg;

  // Bit positions of the individual OPMODE fields
  localparam int OP_X_LSB    = 0;   // X mux select, 2 bits
  localparam int OP_Z_LSB    = 2;   // Z mux select, 2 bits
  localparam int OP_B1_SEL   = 4;   // 1 = pre-adder result feeds B1
  localparam int OP_CARRY    = 5;   // carry-in when sourced from OPMODE
  localparam int OP_PRE_SUB  = 6;   // 1 = pre-adder subtracts
  localparam int OP_POST_SUB = 7;   // 1 = post-adder subtracts
  localparam int MUX_SEL_W   = 2;

  // X mux operand selection
  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } xSel_e;

  // Z mux operand selection
  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } zSel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// ---------------------------------------------------------------------------
// dsp_pipe_reg
// One optional pipeline stage of the DSP slice. With REG=1 it is a register
// with synchronous active-high reset (reset wins over enable); with REG=0 it
// collapses to a plain wire and the control inputs are ignored.
//
// Ports
//   CLK  - clock, rising edge
//   CE   - clock enable, active-high
//   RST  - synchronous reset, active-high
//   i_d  - stage input  [WIDTH-1:0]
//   o_q  - stage output [WIDTH-1:0]
// ---------------------------------------------------------------------------
module dsp_pipe_reg
  import dsp48_a1_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int REG   = 1
) (
  input  logic             CLK,
  input  logic             CE,
  input  logic             RST,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (REG == 1) begin : g_reg
      logic [WIDTH-1:0] r_q;

      // Registered stage: reset clears the stage even while CE is low,
      // otherwise CE low simply holds the current value.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_q <= '0;
        end else if (CE) begin
          r_q <= i_d;
        end
      end

      assign o_q = r_q;
    end else begin : g_bypass
      // Bypassed stage has no clock, enable or reset behaviour at all; the
      // controls are folded into a deliberately unused net.
      logic w_unusedCtrl;
      assign w_unusedCtrl = CLK ^ CE ^ RST;
      assign o_q          = i_d;
    end
  endgenerate

endmodule

// File: rtl/dsp48_a1.sv
// ---------------------------------------------------------------------------
// dsp48_a1
// DSP48A1-style arithmetic slice: 18-bit pre-adder, 18x18 unsigned
// multiplier and 48-bit post-adder/accumulator with optional pipeline stages.
//
// Ports
//   CLK                      - clock, all stages update on the rising edge
//   RSTA/B/C/D/M/P/OPMODE/CARRYIN - per-stage synchronous active-high resets
//   CEA/B/C/D/M/P/OPMODE/CARRYIN  - per-stage clock enables
//   A, B, D, BCIN            - 18-bit operands (BCIN = cascaded B)
//   C, PCIN                  - 48-bit post-adder operand / cascaded P
//   OPMODE                   - 8-bit operation select
//   CARRYIN                  - external carry-in
//   P, PCOUT                 - 48-bit post-adder result (PCOUT mirrors P)
//   M                        - 36-bit multiplier stage output
//   BCOUT                    - 18-bit B1 stage output
//   CARRYOUT, CARRYOUTF      - post-adder carry (CARRYOUTF mirrors CARRYOUT)
// ---------------------------------------------------------------------------
module dsp48_a1
  import dsp48_a1_pkg::*;
#(
  parameter int    WIDTH_1     = 8,
  parameter int    WIDTH_2     = 18,
  parameter int    WIDTH_3     = 36,
  parameter int    WIDTH_4     = 48,
  parameter int    A0REG       = 0,
  parameter int    A1REG       = 1,
  parameter int    B0REG       = 0,
  parameter int    B1REG       = 1,
  parameter int    CREG        = 1,
  parameter int    DREG        = 1,
  parameter int    MREG        = 1,
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter int    OPMODEREG   = 1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT",
  parameter string RSTTYPE     = "SYNC"
) (
  input  logic               CLK,
  input  logic               RSTA,
  input  logic               RSTB,
  input  logic               RSTC,
  input  logic               RSTCARRYIN,
  input  logic               RSTD,
  input  logic               RSTM,
  input  logic               RSTOPMODE,
  input  logic               RSTP,
  input  logic               CEA,
  input  logic               CEB,
  input  logic               CEC,
  input  logic               CECARRYIN,
  input  logic               CED,
  input  logic               CEM,
  input  logic               CEOPMODE,
  input  logic               CEP,
  input  logic [WIDTH_2-1:0] A,
  input  logic [WIDTH_2-1:0] B,
  input  logic [WIDTH_2-1:0] D,
  input  logic [WIDTH_2-1:0] BCIN,
  input  logic [WIDTH_4-1:0] C,
  input  logic [WIDTH_4-1:0] PCIN,
  input  logic [WIDTH_1-1:0] OPMODE,
  input  logic               CARRYIN,
  output logic [WIDTH_4-1:0] P,
  output logic [WIDTH_4-1:0] PCOUT,
  output logic [WIDTH_3-1:0] M,
  output logic [WIDTH_2-1:0] BCOUT,
  output logic               CARRYOUT,
  output logic               CARRYOUTF
);

  // Only synchronous reset exists in this implementation; the parameter is
  // kept for interface compatibility with the original primitive.
  localparam bit lp_unusedRstSync = (RSTTYPE == "SYNC");

  logic [WIDTH_2-1:0] w_a0;
  logic [WIDTH_2-1:0] w_a1;
  logic [WIDTH_2-1:0] w_bSrc;
  logic [WIDTH_2-1:0] w_b0;
  logic [WIDTH_2-1:0] w_b1In;
  logic [WIDTH_2-1:0] w_b1;
  logic [WIDTH_2-1:0] w_d;
  logic [WIDTH_4-1:0] w_c;
  logic [WIDTH_1-1:0] w_opmode;
  logic [WIDTH_2-1:0] w_preAdd;
  logic [WIDTH_3-1:0] w_mult;
  logic [WIDTH_3-1:0] w_m;
  logic               w_carrySel;
  logic               w_cin;
  logic [WIDTH_4-1:0] w_xMux;
  logic [WIDTH_4-1:0] w_zMux;
  logic [WIDTH_4:0]   w_xExt;
  logic [WIDTH_4:0]   w_zExt;
  logic [WIDTH_4:0]   w_cinExt;
  logic [WIDTH_4:0]   w_postSum;
  logic [WIDTH_4-1:0] w_p;
  logic               w_carryOut;

  // A path: two optional stages sharing CEA/RSTA
  dsp_pipe_reg #(.WIDTH(WIDTH_2), .REG(A0REG)) u_a0 (
    .CLK(CLK), .CE(CEA), .RST(RSTA), .i_d(A), .o_q(w_a0)
  );
  dsp_pipe_reg #(.WIDTH(WIDTH_2), .REG(A1REG)) u_a1 (
    .CLK(CLK), .CE(CEA), .RST(RSTA), .i_d(w_a0), .o_q(w_a1)
  );

  // B path source is either the direct input or the cascade input
  assign w_bSrc = (B_INPUT == "CASCADE") ? BCIN : B;

  dsp_pipe_reg #(.WIDTH(WIDTH_2), .REG(B0REG)) u_b0 (
    .CLK(CLK), .CE(CEB), .RST(RSTB), .i_d(w_bSrc), .o_q(w_b0)
  );

  dsp_pipe_reg #(.WIDTH(WIDTH_2), .REG(DREG)) u_d (
    .CLK(CLK), .CE(CED), .RST(RSTD), .i_d(D), .o_q(w_d)
  );

  dsp_pipe_reg #(.WIDTH(WIDTH_4), .REG(CREG)) u_c (
    .CLK(CLK), .CE(CEC), .RST(RSTC), .i_d(C), .o_q(w_c)
  );

  // Every OPMODE-controlled mux below looks at this stage's output, so a
  // new OPMODE takes effect one cycle after it is presented.
  dsp_pipe_reg #(.WIDTH(WIDTH_1), .REG(OPMODEREG)) u_opmode (
    .CLK(CLK), .CE(CEOPMODE), .RST(RSTOPMODE), .i_d(OPMODE), .o_q(w_opmode)
  );

  // Pre-adder wraps at 18 bits; B1 takes either its result or raw B0
  assign w_preAdd = w_opmode[OP_PRE_SUB] ? (w_d - w_b0) : (w_d + w_b0);
  assign w_b1In   = w_opmode[OP_B1_SEL] ? w_preAdd : w_b0;

  dsp_pipe_reg #(.WIDTH(WIDTH_2), .REG(B1REG)) u_b1 (
    .CLK(CLK), .CE(CEB), .RST(RSTB), .i_d(w_b1In), .o_q(w_b1)
  );

  // Unsigned full-width product
  assign w_mult = WIDTH_3'(w_a1) * WIDTH_3'(w_b1);

  dsp_pipe_reg #(.WIDTH(WIDTH_3), .REG(MREG)) u_m (
    .CLK(CLK), .CE(CEM), .RST(RSTM), .i_d(w_mult), .o_q(w_m)
  );

  assign w_carrySel = (CARRYINSEL == "CARRYIN") ? CARRYIN : w_opmode[OP_CARRY];

  dsp_pipe_reg #(.WIDTH(1), .REG(CARRYINREG)) u_cin (
    .CLK(CLK), .CE(CECARRYIN), .RST(RSTCARRYIN), .i_d(w_carrySel), .o_q(w_cin)
  );

  // X operand select. The concatenation option packs D[11:0], A1 and B1
  // into a full 48-bit word so the slice can be used as a wide adder.
  always_comb begin
    w_xMux = '0;
    case (xSel_e'(w_opmode[OP_X_LSB +: MUX_SEL_W]))
      X_ZERO:  w_xMux = '0;
      X_M:     w_xMux = WIDTH_4'(w_m);
      X_P:     w_xMux = w_p;
      X_DAB:   w_xMux = {w_d[11:0], w_a1, w_b1};
      default: w_xMux = '0;
    endcase
  end

  // Z operand select; the P option turns the slice into an accumulator
  always_comb begin
    w_zMux = '0;
    case (zSel_e'(w_opmode[OP_Z_LSB +: MUX_SEL_W]))
      Z_ZERO:  w_zMux = '0;
      Z_PCIN:  w_zMux = PCIN;
      Z_P:     w_zMux = w_p;
      Z_C:     w_zMux = w_c;
      default: w_zMux = '0;
    endcase
  end

  // Post-adder runs one bit wider than P; the extra bit is the carry out
  // on addition and the borrow on subtraction.
  assign w_xExt    = {1'b0, w_xMux};
  assign w_zExt    = {1'b0, w_zMux};
  assign w_cinExt  = {{WIDTH_4{1'b0}}, w_cin};
  assign w_postSum = w_opmode[OP_POST_SUB] ? (w_zExt - (w_xExt + w_cinExt))
                                           : (w_zExt + w_xExt + w_cinExt);

  dsp_pipe_reg #(.WIDTH(WIDTH_4), .REG(PREG)) u_p (
    .CLK(CLK), .CE(CEP), .RST(RSTP), .i_d(w_postSum[WIDTH_4-1:0]), .o_q(w_p)
  );

  dsp_pipe_reg #(.WIDTH(1), .REG(CARRYOUTREG)) u_cout (
    .CLK(CLK), .CE(CEP), .RST(RSTP), .i_d(w_postSum[WIDTH_4]), .o_q(w_carryOut)
  );

  assign P         = w_p;
  assign PCOUT     = w_p;
  assign M         = w_m;
  assign BCOUT     = w_b1;
  assign CARRYOUT  = w_carryOut;
  assign CARRYOUTF = w_carryOut;

endmodule

// File: tb/tb_dsp48_a1.sv
// ---------------------------------------------------------------------------
// tb_dsp48_a1
// Scoreboard bench for dsp48_a1 with default parameters. Stimulus tasks
// push expected results (tagged with the clock edge they belong to) into a
// queue; an independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_dsp48_a1;

  logic        CLK = 1'b0;
  logic        RSTA, RSTB, RSTC, RSTCARRYIN, RSTD, RSTM, RSTOPMODE, RSTP;
  logic        CEA, CEB, CEC, CECARRYIN, CED, CEM, CEOPMODE, CEP;
  logic [17:0] A, B, D, BCIN;
  logic [47:0] C, PCIN;
  logic [7:0]  OPMODE;
  logic        CARRYIN;
  logic [47:0] P, PCOUT;
  logic [35:0] M;
  logic [17:0] BCOUT;
  logic        CARRYOUT, CARRYOUTF;

  always #5 CLK = ~CLK;

  dsp48_a1 dut (
    .CLK(CLK),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTCARRYIN(RSTCARRYIN),
    .RSTD(RSTD), .RSTM(RSTM), .RSTOPMODE(RSTOPMODE), .RSTP(RSTP),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CECARRYIN(CECARRYIN),
    .CED(CED), .CEM(CEM), .CEOPMODE(CEOPMODE), .CEP(CEP),
    .A(A), .B(B), .D(D), .BCIN(BCIN),
    .C(C), .PCIN(PCIN),
    .OPMODE(OPMODE), .CARRYIN(CARRYIN),
    .P(P), .PCOUT(PCOUT), .M(M), .BCOUT(BCOUT),
    .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  // mask bits: 0 = P/PCOUT, 1 = M, 2 = BCOUT, 3 = CARRYOUT/CARRYOUTF
  typedef struct {
    int unsigned due;
    logic [3:0]  mask;
    logic [47:0] p;
    logic [35:0] m;
    logic [17:0] bc;
    logic        co;
    string       tag;
  } expect_t;

  expect_t     expQ[$];
  int unsigned edgeCount = 0;
  int          compared = 0;
  int          mismatched = 0;

  // Number of rising edges seen so far; expectations are keyed to it
  always @(posedge CLK) edgeCount <= edgeCount + 1;

  // Watchdog: guarantees termination even if the stimulus stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [47:0] act, input logic [47:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: compares every expectation that falls due on this edge
  initial begin
    expect_t e;
    forever begin
      @(negedge CLK);
      while (expQ.size() > 0 && expQ[0].due <= edgeCount) begin
        e = expQ.pop_front();
        if (e.due != edgeCount) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL %s_late: sampled at edge %0d, expected edge %0d", e.tag, edgeCount, e.due);
        end else begin
          if (e.mask[0]) checkOutput({e.tag, "_P"}, P, e.p);
          if (e.mask[0]) checkOutput({e.tag, "_PCOUT"}, PCOUT, e.p);
          if (e.mask[1]) checkOutput({e.tag, "_M"}, 48'(M), 48'(e.m));
          if (e.mask[2]) checkOutput({e.tag, "_BCOUT"}, 48'(BCOUT), 48'(e.bc));
          if (e.mask[3]) checkOutput({e.tag, "_CARRYOUT"}, 48'(CARRYOUT), 48'(e.co));
          if (e.mask[3]) checkOutput({e.tag, "_CARRYOUTF"}, 48'(CARRYOUTF), 48'(e.co));
        end
      end
    end
  end

  // Steady-state reference: what the slice produces once held inputs have
  // flowed through every stage. P-feedback selections are not modelled here.
  function automatic expect_t refModel(input logic [17:0] a, input logic [17:0] b,
                                       input logic [17:0] d, input logic [47:0] c,
                                       input logic [47:0] pcin, input logic [7:0] op);
    expect_t e;
    longint  x, z, cin, total;
    logic [47:0] dab;
    if (op[4]) e.bc = op[6] ? 18'(d - b) : 18'(d + b);
    else       e.bc = b;
    e.m = 36'(a) * 36'(e.bc);
    dab = {d[11:0], a, e.bc};
    case (op[1:0])
      2'd1:    x = longint'(e.m);
      2'd3:    x = longint'(dab);
      default: x = 0;
    endcase
    case (op[3:2])
      2'd1:    z = longint'(pcin);
      2'd3:    z = longint'(c);
      default: z = 0;
    endcase
    cin   = longint'(op[5]);
    total = op[7] ? (z - (x + cin)) : (z + x + cin);
    e.p   = total[47:0];
    e.co  = total[48];
    e.mask = 4'hF;
    e.due  = 0;
    e.tag  = "";
    return e;
  endfunction

  task automatic pushExp(input int unsigned due, input logic [3:0] mask, input logic [47:0] p,
                         input logic [35:0] m, input logic [17:0] bc, input logic co, input string tag);
    expect_t e;
    e.due = due; e.mask = mask; e.p = p; e.m = m; e.bc = bc; e.co = co; e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic setAllResets(input logic v);
    RSTA = v; RSTB = v; RSTC = v; RSTCARRYIN = v; RSTD = v; RSTM = v; RSTOPMODE = v; RSTP = v;
  endtask

  task automatic setAllEnables(input logic v);
    CEA = v; CEB = v; CEC = v; CECARRYIN = v; CED = v; CEM = v; CEOPMODE = v; CEP = v;
  endtask

  // Drive one operand set, hold it four edges, expect the steady-state result
  task automatic applyStimulus(input logic [17:0] a, input logic [17:0] b, input logic [17:0] d,
                               input logic [47:0] c, input logic [47:0] pcin, input logic [7:0] op,
                               input logic cinExt, input string tag);
    expect_t e;
    A = a; B = b; D = d; C = c; PCIN = pcin; OPMODE = op; CARRYIN = cinExt;
    BCIN = 18'($urandom);
    e = refModel(a, b, d, c, pcin, op);
    e.due = edgeCount + 4;
    e.tag = tag;
    expQ.push_back(e);
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] op;
    int unsigned base;
    setAllResets(1'b0);
    setAllEnables(1'b1);
    A = 18'h2AAAA; B = 18'h15555; D = 18'h3FFFF; BCIN = '0;
    C = 48'hDEAD_BEEF_0001; PCIN = 48'h1234_5678_9ABC; OPMODE = 8'hFF; CARRYIN = 1'b1;
    repeat (3) @(negedge CLK);
    $display("[TB] start");

    // Let garbage settle into every stage, then reset with all CEs low
    setAllEnables(1'b0);
    setAllResets(1'b1);
    pushExp(edgeCount + 1, 4'hF, 48'd0, 36'd0, 18'd0, 1'b0, "reset_ce_low");
    @(negedge CLK);
    setAllResets(1'b0);
    setAllEnables(1'b1);

    // Latency from a cleared pipeline: BCOUT after 1 edge, M after 2, P after 3
    A = 18'd3; B = 18'd5; D = 18'd0; C = 48'd0; PCIN = 48'd0; OPMODE = 8'b0000_0001; CARRYIN = 1'b0;
    setAllResets(1'b1);
    pushExp(edgeCount + 1, 4'hF, 48'd0, 36'd0, 18'd0, 1'b0, "reset_all");
    @(negedge CLK);
    setAllResets(1'b0);
    base = edgeCount;
    pushExp(base + 1, 4'b0100, 48'd0, 36'd0, 18'd5, 1'b0, "lat_bcout");
    pushExp(base + 2, 4'b0110, 48'd0, 36'd15, 18'd5, 1'b0, "lat_m");
    pushExp(base + 3, 4'b1111, 48'd15, 36'd15, 18'd5, 1'b0, "lat_p");
    repeat (3) @(negedge CLK);

    // Directed operand sets from the datasheet examples
    applyStimulus(18'd2, 18'd4, 18'd10, 48'd0, 48'd0, 8'b0001_0001, 1'b0, "preadd_add");
    applyStimulus(18'd2, 18'd4, 18'd10, 48'd0, 48'd0, 8'b0101_0001, 1'b0, "preadd_sub");
    applyStimulus(18'd3, 18'd5, 18'd0, 48'd100, 48'd0, 8'b0010_1100, 1'b0, "c_plus_cin");
    applyStimulus(18'd3, 18'd5, 18'd0, 48'd100, 48'd0, 8'b1000_1101, 1'b0, "c_minus_m");
    applyStimulus(18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 8'b0000_1101, 1'b0, "carry_wrap");
    applyStimulus(18'd0, 18'd1, 18'd0, 48'd0, 48'd0, 8'b1010_0000, 1'b1, "borrow");
    applyStimulus(18'h3FFFF, 18'h3FFFF, 18'd0, 48'd0, 48'd0, 8'b0000_0001, 1'b0, "max_product");
    applyStimulus(18'h00003, 18'h00001, 18'h3FFFF, 48'd0, 48'd0, 8'b0001_0001, 1'b0, "preadd_wrap");

    // Randomised operand sets, avoiding the P feedback selections
    for (int i = 0; i < 30; i++) begin
      do op = 8'($urandom); while (op[1:0] == 2'd2 || op[3:2] == 2'd2);
      applyStimulus(18'($urandom), 18'($urandom), 18'($urandom),
                    {16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                    op, 1'($urandom), $sformatf("rand%0d_op%02h", i, op));
    end

    // Accumulator: P += A*B each cycle once the product reaches the adder,
    // i.e. P is k-2 after the k-th edge following reset; CEP low freezes P.
    A = 18'd1; B = 18'd1; D = 18'd0; C = 48'd0; PCIN = 48'd0; OPMODE = 8'b0000_1001; CARRYIN = 1'b0;
    setAllResets(1'b1);
    pushExp(edgeCount + 1, 4'hF, 48'd0, 36'd0, 18'd0, 1'b0, "acc_reset");
    @(negedge CLK);
    setAllResets(1'b0);
    base = edgeCount;
    for (int k = 1; k <= 8; k++)
      pushExp(base + k, 4'b1001, (k < 2) ? 48'd0 : 48'(k - 2), 36'd0, 18'd0, 1'b0, $sformatf("acc_k%0d", k));
    for (int k = 9; k <= 11; k++)
      pushExp(base + k, 4'b1001, 48'd6, 36'd0, 18'd0, 1'b0, $sformatf("acc_hold_k%0d", k));
    pushExp(base + 12, 4'b1001, 48'd7, 36'd0, 18'd0, 1'b0, "acc_resume1");
    pushExp(base + 13, 4'b1001, 48'd8, 36'd0, 18'd0, 1'b0, "acc_resume2");
    repeat (8) @(negedge CLK);
    CEP = 1'b0;
    repeat (3) @(negedge CLK);
    CEP = 1'b1;
    repeat (4) @(negedge CLK);

    // Any expectation never reached counts as a failure
    while (expQ.size() > 0) begin
      expect_t e;
      e = expQ.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_unchecked: still pending at edge %0d, expected edge %0d", e.tag, edgeCount, e.due);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
